// File: rtl/timing_loop_ctrl.sv
// Symbol-strobe NCO and IDLE/FLUSH/ACQ/TRACK sequencer for the MSK timing-recovery loop.
// Latency: sym_valid_o/mu_o one clk after the iq_val_i sample that wraps the phase accumulator.
// Backpressure: none; the loop advances only on iq_val_i and e_valid_i, never stalls upstream.
module timing_loop_ctrl #(
    parameter int OSF        = 20,
    parameter int WE         = 18,
    parameter int WP         = 24,
    parameter int WMU        = 12,
    parameter int ACQ_SYMS   = 256,
    parameter int LOCK_WIN   = 64,
    parameter int LOCK_THR   = 2**20,
    parameter int UNLOCK_THR = 2**22
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable_i,
    input  logic           iq_val_i,
    input  logic [WE-1:0]  ctrl_i,
    input  logic [WE-1:0]  e_in,
    input  logic           e_valid_i,
    output logic           sym_valid_o,
    output logic [WMU-1:0] mu_o,
    output logic           gain_sel_o,
    output logic           lf_clear_o,
    output logic           locked_o,
    output logic [1:0]     state_o
);

    localparam int SW = $clog2(OSF + 1);
    localparam int CW = $clog2(ACQ_SYMS);
    localparam int LW = $clog2(LOCK_WIN);
    localparam int WS = WE + LW;
    localparam longint NOM_L = ((longint'(1) << WP) + OSF - 1) / OSF;
    localparam logic [WP:0]        NOM_STEP = (WP+1)'(NOM_L);
    localparam logic signed [WP:0] ADJ_MAX  = (WP+1)'(NOM_L >> 3);

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, ACQ = 2'd2, TRACK = 2'd3} state_t;

    state_t         state_q, state_d;
    logic [WP-1:0]  acc_q;
    logic [SW-1:0]  samp_q;
    logic [CW-1:0]  sym_cnt_q;
    logic [WS-1:0]  sum_q;
    logic [LW-1:0]  win_q;

    logic signed [WP:0] ctrl_ext, adj;
    logic [WP:0]        step, acc_sum;
    logic [WE-1:0]      e_abs;
    logic [WS:0]        sum_ext;
    logic [WS-1:0]      sum_sat;
    logic               run, win_end, lock_good, lock_bad;

    always_comb begin
        ctrl_ext = {{(WP+1-WE){ctrl_i[WE-1]}}, ctrl_i};
        if (ctrl_ext > ADJ_MAX)
            adj = ADJ_MAX;
        else if (ctrl_ext < -ADJ_MAX)
            adj = -ADJ_MAX;
        else
            adj = ctrl_ext;
        step    = NOM_STEP + $unsigned(adj);
        acc_sum = {1'b0, acc_q} + step;
        // most-negative error maps to 2**(WE-1), which still fits unsigned in WE bits
        e_abs   = e_in[WE-1] ? (~e_in + WE'(1)) : e_in;
        sum_ext = {1'b0, sum_q} + (WS+1)'(e_abs);
        sum_sat = sum_ext[WS] ? {WS{1'b1}} : sum_ext[WS-1:0];
        run       = (state_q == ACQ) || (state_q == TRACK);
        win_end   = run && e_valid_i && (win_q == LW'(LOCK_WIN - 1));
        lock_good = sum_sat < WS'(LOCK_THR);
        lock_bad  = sum_sat >= WS'(UNLOCK_THR);
    end

    always_comb begin
        state_d    = state_q;
        lf_clear_o = 1'b1;
        gain_sel_o = 1'b0;
        case (state_q)
            IDLE:  state_d = FLUSH;
            FLUSH: if (iq_val_i && samp_q == SW'(OSF)) state_d = ACQ;
            ACQ: begin
                lf_clear_o = 1'b0;
                if (sym_valid_o && sym_cnt_q == CW'(ACQ_SYMS - 1)) state_d = TRACK;
            end
            TRACK: begin
                lf_clear_o = 1'b0;
                gain_sel_o = 1'b1;
                if (win_end && lock_bad) state_d = ACQ;
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i) state_d = IDLE;
    end

    assign state_o = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            samp_q      <= '0;
            sym_cnt_q   <= '0;
            sum_q       <= '0;
            win_q       <= '0;
            sym_valid_o <= 1'b0;
            mu_o        <= '0;
            locked_o    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_valid_o <= 1'b0;
            if (state_d == IDLE) begin
                acc_q     <= '0;
                samp_q    <= '0;
                sym_cnt_q <= '0;
                sum_q     <= '0;
                win_q     <= '0;
                mu_o      <= '0;
                locked_o  <= 1'b0;
            end else if (state_q == FLUSH) begin
                // everything downstream of the flush starts from zero on entry to ACQ
                if (iq_val_i) samp_q <= samp_q + SW'(1);
                acc_q     <= '0;
                sym_cnt_q <= '0;
                sum_q     <= '0;
                win_q     <= '0;
            end else if (run) begin
                if (iq_val_i) begin
                    acc_q <= acc_sum[WP-1:0];
                    if (acc_sum[WP]) begin
                        sym_valid_o <= 1'b1;
                        mu_o        <= acc_sum[WP-1 -: WMU];
                    end
                end
                if (state_q == ACQ && sym_valid_o) sym_cnt_q <= sym_cnt_q + CW'(1);
                if (state_q == TRACK && state_d == ACQ) sym_cnt_q <= '0;
                if (e_valid_i) begin
                    if (win_end) begin
                        sum_q <= '0;
                        win_q <= '0;
                        if (lock_good)
                            locked_o <= 1'b1;
                        else if (lock_bad)
                            locked_o <= 1'b0;
                    end else begin
                        sum_q <= sum_sat;
                        win_q <= win_q + LW'(1);
                    end
                end
                // a fresh window starts with tracking gains
                if (state_q == ACQ && state_d == TRACK) begin
                    sum_q <= '0;
                    win_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Randomized bench for timing_loop_ctrl against an arithmetic model of the loop rules.
module tb_timing_loop_ctrl;
    localparam int OSF = 20;
    localparam int WE  = 18;
    localparam int WP  = 24;
    localparam int WMU = 12;
    localparam longint FULL = longint'(1) << WP;
    localparam longint NOM  = (FULL + OSF - 1) / OSF;
    localparam longint ADJM = NOM / 8;
    localparam logic [17:0] IDLE_VEC = 18'h00002;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           enable_i = 1'b0;
    logic           iq_val_i = 1'b0;
    logic [WE-1:0]  ctrl_i = '0;
    logic [WE-1:0]  e_in = '0;
    logic           e_valid_i = 1'b0;
    logic           sym_valid_o;
    logic [WMU-1:0] mu_o;
    logic           gain_sel_o;
    logic           lf_clear_o;
    logic           locked_o;
    logic [1:0]     state_o;

    int checks = 0;
    int errors = 0;

    timing_loop_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .iq_val_i(iq_val_i),
        .ctrl_i(ctrl_i), .e_in(e_in), .e_valid_i(e_valid_i),
        .sym_valid_o(sym_valid_o), .mu_o(mu_o), .gain_sel_o(gain_sel_o),
        .lf_clear_o(lf_clear_o), .locked_o(locked_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [17:0] dut_vec;
    assign dut_vec = {state_o, sym_valid_o, mu_o, gain_sel_o, lf_clear_o, locked_o};

    // Reference: phase as an integer modulo 2**WP, symbol/sample/error tallies as plain counts.
    int     m_state, m_samp, m_syms, m_wcnt, m_mu;
    longint m_acc, m_sum;
    bit     m_sv, m_locked;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !enable_i) begin
            m_state = 0; m_samp = 0; m_syms = 0; m_wcnt = 0; m_mu = 0;
            m_acc = 0; m_sum = 0; m_sv = 0; m_locked = 0;
        end else begin
            bit prev_sv, go_track, go_acq;
            longint c, e;
            prev_sv = m_sv; m_sv = 0; go_track = 0; go_acq = 0;
            case (m_state)
                0: begin m_state = 1; m_samp = 0; end
                1: if (iq_val_i) begin
                    m_samp++;
                    if (m_samp == OSF + 1) begin
                        m_state = 2; m_acc = 0; m_syms = 0; m_sum = 0; m_wcnt = 0;
                    end
                end
                default: begin
                    c = longint'($signed(ctrl_i));
                    if (c > ADJM) c = ADJM; else if (c < -ADJM) c = -ADJM;
                    if (iq_val_i) begin
                        m_acc += NOM + c;
                        if (m_acc >= FULL) begin
                            m_acc -= FULL; m_sv = 1; m_mu = int'(m_acc >> (WP - WMU));
                        end
                    end
                    if (m_state == 2 && prev_sv) begin m_syms++; go_track = (m_syms == 256); end
                    if (e_valid_i) begin
                        e = longint'($signed(e_in));
                        if (e < 0) e = -e;
                        m_sum += e;
                        if (m_sum > FULL - 1) m_sum = FULL - 1;
                        m_wcnt++;
                        if (m_wcnt == 64) begin
                            if (m_sum < 2**20) m_locked = 1;
                            else if (m_sum >= 2**22) begin m_locked = 0; go_acq = (m_state == 3); end
                            m_sum = 0; m_wcnt = 0;
                        end
                    end
                    if (go_track) begin m_state = 3; m_sum = 0; m_wcnt = 0; end
                    if (go_acq) begin m_state = 2; m_syms = 0; end
                end
            endcase
        end
    end

    function automatic logic [17:0] exp_vec();
        return {2'(m_state), m_sv, 12'(m_mu), (m_state == 3), (m_state < 2), m_locked};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; enable_i = 1'b0; iq_val_i = 1'b0; e_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dut_vec !== IDLE_VEC) begin errors++; $display("FAIL reset_vals got=%h want=%h", dut_vec, IDLE_VEC); end
        checks++; if (lf_clear_o !== 1'b1) begin errors++; $display("FAIL reset_lf_clear got=%b want=1", lf_clear_o); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_startup();
        int t_fl, t_acq, t_sv1, t_sv2, mu1;
        logic lf_at_acq;
        t_fl = -1; t_acq = -1; t_sv1 = -1; t_sv2 = -1; mu1 = -1; lf_at_acq = 1'b1;
        ctrl_i = '0; iq_val_i = 1'b1; e_valid_i = 1'b0; enable_i = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL startup_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
            if (state_o == 2'd1 && t_fl < 0) t_fl = n;
            if (state_o == 2'd2 && t_acq < 0) begin t_acq = n; lf_at_acq = lf_clear_o; end
            if (sym_valid_o) begin
                if (t_sv1 < 0) begin t_sv1 = n; mu1 = int'(mu_o); end
                else if (t_sv2 < 0) t_sv2 = n;
            end
        end
        checks++; if (t_fl != 1) begin errors++; $display("FAIL startup_flush_clk got=%0d want=1", t_fl); end
        checks++; if (t_acq != 22) begin errors++; $display("FAIL startup_acq_clk got=%0d want=22", t_acq); end
        checks++; if (lf_at_acq !== 1'b0) begin errors++; $display("FAIL startup_lf_clear got=%b want=0", lf_at_acq); end
        checks++; if (t_sv1 != 42) begin errors++; $display("FAIL startup_first_strobe got=%0d want=42", t_sv1); end
        checks++; if (t_sv2 != 62) begin errors++; $display("FAIL startup_second_strobe got=%0d want=62", t_sv2); end
        checks++; if (mu1 != 0) begin errors++; $display("FAIL startup_mu got=%0d want=0", mu1); end
    endtask

    task automatic test_ctrl_clamp();
        int last, ns;
        for (int pass = 0; pass < 2; pass++) begin
            ctrl_i = (pass == 0) ? 18'h1FFFF : 18'h20000;
            last = -1; ns = 0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clk);
                checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL clamp_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
                if (sym_valid_o) begin
                    ns++;
                    if (ns > 2) begin
                        checks++;
                        if ((pass == 0 && (n - last < 17 || n - last > 18)) || (pass == 1 && (n - last < 22 || n - last > 23))) begin
                            errors++; $display("FAIL clamp_period pass=%0d got=%0d want=%s", pass, n - last, pass == 0 ? "17..18" : "22..23");
                        end
                    end
                    last = n;
                end
            end
        end
        for (int n = 0; n < 300; n++) begin
            ctrl_i = 18'($urandom);
            @(negedge clk);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ctrl_rand_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_track_lock();
        int n, cnt, k;
        logic prev_sv;
        enable_i = 1'b0; @(negedge clk);
        enable_i = 1'b1; iq_val_i = 1'b1; e_valid_i = 1'b0;
        n = 0;
        while (state_o != 2'd2 && n < 100) begin
            @(negedge clk); n++;
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL track_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
        end
        cnt = 0; prev_sv = 1'b0; n = 0;
        while (state_o == 2'd2 && n < 8000) begin
            prev_sv = sym_valid_o;
            if (prev_sv) cnt++;
            ctrl_i = 18'($urandom);
            @(negedge clk); n++;
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL track_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
        end
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL track_entry got=%0d want=3", state_o); end
        checks++; if (cnt != 256) begin errors++; $display("FAIL track_strobes got=%0d want=256", cnt); end
        checks++; if (prev_sv !== 1'b1 || gain_sel_o !== 1'b1) begin errors++; $display("FAIL track_gain_timing got=%b%b want=11", prev_sv, gain_sel_o); end
        k = 0;
        while (k < 64) begin
            e_valid_i = ($urandom_range(0, 3) != 0);
            e_in = ($urandom_range(0, 1) == 1) ? 18'd100 : 18'h3FF9C;
            if (e_valid_i) k++;
            @(negedge clk);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL lock_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
            if (k == 63 && e_valid_i) begin
                checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_early got=%b want=0", locked_o); end
            end
        end
        e_valid_i = 1'b0;
        checks++; if (locked_o !== 1'b1 || state_o !== 2'd3) begin errors++; $display("FAIL lock_set got=%b/%0d want=1/3", locked_o, state_o); end
        e_in = 18'h20000; e_valid_i = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL unlock_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
            if (i == 63) begin
                checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_hold got=%b want=1", locked_o); end
            end
        end
        e_valid_i = 1'b0;
        checks++; if (locked_o !== 1'b0 || state_o !== 2'd2 || gain_sel_o !== 1'b0) begin
            errors++; $display("FAIL unlock got=%b/%0d/%b want=0/2/0", locked_o, state_o, gain_sel_o);
        end
    endtask

    task automatic test_disable();
        int n;
        repeat (7) @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        checks++; if (dut_vec !== IDLE_VEC) begin errors++; $display("FAIL disable_acq got=%h want=%h", dut_vec, IDLE_VEC); end
        test_startup();
        n = 0;
        while (state_o != 2'd3 && n < 8000) begin
            @(negedge clk); n++;
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL disable_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
        end
        checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL disable_reach_track got=%0d want=3", state_o); end
        e_valid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            e_in = 18'($urandom_range(0, 500));
            if ($urandom_range(0, 1) == 1) e_in = -e_in;
            @(negedge clk);
        end
        e_valid_i = 1'b0;
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL disable_prelock got=%b want=1", locked_o); end
        repeat (9) @(negedge clk);
        enable_i = 1'b0;
        @(negedge clk);
        checks++; if (dut_vec !== IDLE_VEC) begin errors++; $display("FAIL disable_track got=%h want=%h", dut_vec, IDLE_VEC); end
        test_startup();
    endtask

    task automatic test_async_reset();
        int last, ns;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dut_vec !== IDLE_VEC) begin errors++; $display("FAIL async_reset got=%h want=%h", dut_vec, IDLE_VEC); end
        @(negedge clk);
        reset_n = 1'b1; enable_i = 1'b1; ctrl_i = '0;
        last = -1; ns = 0;
        for (int n = 0; n < 1200; n++) begin
            iq_val_i = (n % 4 == 0);
            @(negedge clk);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL gap_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
            if (sym_valid_o) begin
                ns++;
                if (last >= 0) begin
                    checks++; if (n - last != 80) begin errors++; $display("FAIL gap_period got=%0d want=80", n - last); end
                end
                last = n;
            end
        end
        checks++; if (ns < 12) begin errors++; $display("FAIL gap_strobe_count got=%0d want>=12", ns); end
        iq_val_i = 1'b1;
    endtask

    task automatic test_random();
        int mode;
        logic [WE-1:0] tmp;
        mode = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) mode = $urandom_range(0, 1);
            enable_i  = ($urandom_range(0, 599) != 0);
            iq_val_i  = ($urandom_range(0, 3) != 0);
            ctrl_i    = 18'($urandom);
            e_valid_i = ($urandom_range(0, 1) == 1);
            tmp = (mode == 1) ? 18'($urandom) : 18'($urandom_range(0, 1200));
            e_in = ($urandom_range(0, 1) == 1) ? tmp : -tmp;
            if ($urandom_range(0, 15) == 0) e_in = 18'h20000;
            @(negedge clk);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_model t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_ctrl_clamp();
        test_track_lock();
        test_disable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
